pll_ctrl: RTL and testbench
===========================

Name: pll_ctrl

Overview:
Parametrised ECP5 clock manager wrapping one EHXPLLL with up to four output clocks (CLKOP feedback plus CLKOS/CLKOS2/CLKOS3). It sequences PLL reset, filters LOCK, and releases per-channel downstream resets only after a stable lock. It re-locks automatically on lock loss and performs handshaked dynamic phase steps on any output. It sits at the top of every board design, replacing hand-edited fixed-frequency PLL wrappers.

Parameters:
CLKI_DIV, 1, PLL input divider (1-128)
CLKFB_DIV, 1, PLL feedback divider (1-128)
CLKOP_DIV, 8, CLKOP divider; CLKOP is always the feedback path
CLKOS_DIV, 8, CLKOS divider
CLKOS2_DIV, 8, CLKOS2 divider
CLKOS3_DIV, 8, CLKOS3 divider
NUM_OUT, 2, enabled outputs 1-4; unused outputs are disabled and their rst_out_n bits are held 0
RST_CYCLES, 16, clkin cycles PLL RST is held high per attempt
LOCK_FILTER, 1024, consecutive LOCK-high cycles required before RUN
LOCK_TIMEOUT, 2^20, clkin cycles in WAIT_LOCK before a retry
PS_SETUP, 4, clkin cycles of PHASESEL/PHASEDIR setup and hold around a step pulse
PS_PULSE, 4, clkin cycles PHASESTEP is held low

Ports:
clkin  input  1  reference clock; all control logic runs on it
reset_n  input  1  asynchronous active-low reset
clkout  output  4  PLL output clocks: [0]=CLKOP, [1]=CLKOS, [2]=CLKOS2, [3]=CLKOS3
rst_out_n  output  4  per-channel active-low downstream resets, clkin domain
locked  output  1  filtered lock; high only in RUN and PHASE states
ps_req  input  1  phase-step request, level, sampled in RUN
ps_sel  input  2  output channel to step (0-3)
ps_dir  input  1  1=lag, 0=lead
ps_busy  output  1  high from request acceptance to completion
ps_done  output  1  single-cycle pulse when a step finishes
relock_count  output  8  saturating count of lock losses and timeouts
state  output  3  FSM state code, for debug

Behaviour:
- Reset (reset_n=0, async): state=RST_HOLD, PLL RST=1, all counters 0.
- Reset outputs: rst_out_n=0, locked=0, ps_busy=0, ps_done=0, relock_count=0, PHASESTEP=1, PHASESEL=0, PHASEDIR=0.
- LOCK is passed through a 2-flop synchroniser before any use; this adds 2 cycles to all lock-related latencies.
- RST_HOLD(0): hold PLL RST=1 for RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK(1): RST=0 and count cycles.
  - If synced LOCK=1, go to STABLE with the filter counter cleared.
  - If the counter reaches LOCK_TIMEOUT, increment relock_count and go to RST_HOLD.
- STABLE(2): the filter counter increments while synced LOCK=1.
  - Any LOCK=0 cycle sends the FSM back to WAIT_LOCK with the timeout counter cleared.
  - When the filter count reaches LOCK_FILTER, go to RUN.
- RUN(3): locked=1.
  - rst_out_n[i] deasserts at RUN entry + i cycles, for i<NUM_OUT (staggered release).
  - LOCK=0 in RUN or any PHASE state: rst_out_n=0 on the same cycle, locked=0, relock_count++, go to RST_HOLD. Any in-flight phase step is aborted: ps_busy drops, no ps_done, PHASESTEP returns to 1.
- Phase step, accepted only in RUN with ps_req=1 and ps_sel<NUM_OUT. Requests with ps_sel>=NUM_OUT are ignored and ps_busy stays 0.
  - PS_SETUP(4): latch sel/dir, drive PHASESEL/PHASEDIR, ps_busy=1, wait PS_SETUP cycles.
  - PS_PULSE(5): PHASESTEP=0 for PS_PULSE cycles.
  - PS_HOLD(6): PHASESTEP=1, PHASESEL/PHASEDIR held for PS_SETUP cycles.
  - Then ps_done=1 for one cycle, ps_busy=0, return to RUN.
  - Total step latency from acceptance to ps_done = 2*PS_SETUP+PS_PULSE+1 cycles.
  - ps_req still high after ps_done starts a new step on the next cycle; each step is exactly one VCO phase increment.
- rst_out_n and locked remain asserted-released through PHASE states (steps are glitch-free by PLL design).
- relock_count saturates at 255 and never wraps.
- Parameter range violations (for example NUM_OUT=0 or >4) are caught by an elaboration-time check.
- PLLWAKESYNC=0, STDBY=0, PHASELOADREG=1; CLKINTFB is unused.

Test Plan:
- Reset/lock: model LOCK rising 50 cycles after RST falls (RST_CYCLES=16, LOCK_FILTER=8) -> RST high for 16 cycles, locked rises at 16+50+2+8 cycles ±1, rst_out_n[0..1] release on consecutive cycles, rst_out_n[3:2]=0.
- Lock glitch in STABLE: LOCK low 1 cycle at filter count 5 -> back to WAIT_LOCK, locked stays 0, relock_count unchanged.
- Timeout: LOCK never asserts, LOCK_TIMEOUT=100 -> RST re-pulses every 116 cycles, relock_count increments each time and saturates at 255 after 255 retries.
- Phase step: ps_req with ps_sel=1, ps_dir=1 in RUN -> PHASESEL=1 and PHASEDIR=1 for 4 cycles, then PHASESTEP low exactly 4 cycles, then ps_done at acceptance+13; ps_req held -> second step begins immediately after.
- Abort: LOCK drops during PS_PULSE -> same-cycle rst_out_n=0 and PHASESTEP=1, no ps_done, relock_count=1, full re-lock sequence follows.
- Async reset in RUN: reset_n low mid-cycle -> all outputs return to reset values without waiting for a clkin edge.

Source files
------------

// File: rtl/pll_ctrl.sv
// pll_ctrl: ECP5 EHXPLLL manager. Sequences PLL reset, filters LOCK,
// stages per-channel resets, re-locks on loss and runs phase steps.
// Ports: clkin/reset_n in; clkout[3:0] PLL clocks; rst_out_n[3:0]
// downstream resets; locked; ps_req/ps_sel/ps_dir in, ps_busy/ps_done
// out; relock_count (saturating); state (debug FSM code).
module pll_ctrl #(
  parameter int CLKI_DIV     = 1,
  parameter int CLKFB_DIV    = 1,
  parameter int CLKOP_DIV    = 8,
  parameter int CLKOS_DIV    = 8,
  parameter int CLKOS2_DIV   = 8,
  parameter int CLKOS3_DIV   = 8,
  parameter int NUM_OUT      = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 1 << 20,
  parameter int PS_SETUP     = 4,
  parameter int PS_PULSE     = 4
) (
  input  logic       clkin,
  input  logic       reset_n,
  output logic [3:0] clkout,
  output logic [3:0] rst_out_n,
  output logic       locked,
  input  logic       ps_req,
  input  logic [1:0] ps_sel,
  input  logic       ps_dir,
  output logic       ps_busy,
  output logic       ps_done,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  if (NUM_OUT < 1 || NUM_OUT > 4 ||
      CLKI_DIV < 1 || CLKI_DIV > 128 ||
      CLKFB_DIV < 1 || CLKFB_DIV > 128 ||
      CLKOP_DIV < 1 || CLKOP_DIV > 128 ||
      CLKOS_DIV < 1 || CLKOS_DIV > 128 ||
      CLKOS2_DIV < 1 || CLKOS2_DIV > 128 ||
      CLKOS3_DIV < 1 || CLKOS3_DIV > 128 ||
      RST_CYCLES < 1 || LOCK_FILTER < 1 ||
      LOCK_TIMEOUT < 1 || PS_SETUP < 1 ||
      PS_PULSE < 1) begin : g_param_check
    $error("pll_ctrl: parameter out of range");
  end

  function automatic int maxi(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = maxi(maxi(RST_CYCLES, LOCK_FILTER),
                        maxi(LOCK_TIMEOUT, maxi(PS_SETUP, PS_PULSE)));
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [3:0] EN = 4'((1 << NUM_OUT) - 1);
  localparam logic [2:0] NOUT = 3'(NUM_OUT);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_PSET   = 3'd4,
    S_PPUL   = 3'd5,
    S_PHLD   = 3'd6
  } st_t;

  st_t          st, nst;
  logic [CW-1:0] cnt, ncnt;
  logic         lk_s1, lk;
  logic [7:0]   relock;
  logic [1:0]   sel_q;
  logic         dir_q;
  logic [2:0]   rel;
  logic         done_q;
  logic         bump, accept;
  logic         ps_phase, run_like, active;
  logic         pll_rst, phasestep, lock_raw;
  logic [1:0]   phasesel;
  logic         phasedir;

  assign ps_phase = (st == S_PSET) || (st == S_PPUL) || (st == S_PHLD);
  assign run_like = (st == S_RUN) || ps_phase;
  // Gating by the synced lock drops resets on the same cycle loss is seen.
  assign active   = run_like && lk;

  always_comb begin
    nst    = st;
    ncnt   = cnt + 1'b1;
    bump   = 1'b0;
    accept = 1'b0;
    if (run_like && !lk) begin
      nst  = S_RST;
      ncnt = '0;
      bump = 1'b1;
    end else begin
      unique case (st)
        S_RST: if (cnt == CW'(RST_CYCLES - 1)) begin
          nst  = S_WAIT;
          ncnt = '0;
        end
        S_WAIT: if (lk) begin
          nst  = S_STABLE;
          ncnt = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          nst  = S_RST;
          ncnt = '0;
          bump = 1'b1;
        end
        S_STABLE: if (!lk) begin
          nst  = S_WAIT;
          ncnt = '0;
        end else if (cnt == CW'(LOCK_FILTER - 1)) begin
          nst  = S_RUN;
          ncnt = '0;
        end
        S_RUN: begin
          ncnt = '0;
          if (ps_req && ({1'b0, ps_sel} < NOUT)) begin
            nst    = S_PSET;
            accept = 1'b1;
          end
        end
        S_PSET: if (cnt == CW'(PS_SETUP - 1)) begin
          nst  = S_PPUL;
          ncnt = '0;
        end
        S_PPUL: if (cnt == CW'(PS_PULSE - 1)) begin
          nst  = S_PHLD;
          ncnt = '0;
        end
        S_PHLD: if (cnt == CW'(PS_SETUP - 1)) begin
          nst  = S_RUN;
          ncnt = '0;
        end
        default: begin
          nst  = S_RST;
          ncnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      st     <= S_RST;
      cnt    <= '0;
      lk_s1  <= 1'b0;
      lk     <= 1'b0;
      relock <= '0;
      sel_q  <= '0;
      dir_q  <= 1'b0;
      rel    <= '0;
      done_q <= 1'b0;
    end else begin
      st     <= nst;
      cnt    <= ncnt;
      lk_s1  <= lock_raw;
      lk     <= lk_s1;
      if (bump && relock != 8'hff)
        relock <= relock + 1'b1;
      if (accept) begin
        sel_q <= ps_sel;
        dir_q <= ps_dir;
      end
      rel    <= active ? {rel[1:0], 1'b1} : 3'b000;
      done_q <= (st == S_PHLD) && (nst == S_RUN);
    end
  end

  assign pll_rst      = (st == S_RST);
  assign phasestep    = !((st == S_PPUL) && lk);
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign locked       = active;
  assign rst_out_n    = active ? ({rel, 1'b1} & EN) : 4'b0000;
  assign ps_busy      = ps_phase && lk;
  assign ps_done      = done_q;
  assign relock_count = relock;
  assign state        = st;

`ifdef SYNTHESIS
  EHXPLLL #(
    .CLKI_DIV      (CLKI_DIV),
    .CLKFB_DIV     (CLKFB_DIV),
    .CLKOP_DIV     (CLKOP_DIV),
    .CLKOS_DIV     (CLKOS_DIV),
    .CLKOS2_DIV    (CLKOS2_DIV),
    .CLKOS3_DIV    (CLKOS3_DIV),
    .CLKOP_CPHASE  (CLKOP_DIV - 1),
    .CLKOS_CPHASE  (CLKOS_DIV - 1),
    .CLKOS2_CPHASE (CLKOS2_DIV - 1),
    .CLKOS3_CPHASE (CLKOS3_DIV - 1),
    .CLKOP_FPHASE  (0),
    .CLKOS_FPHASE  (0),
    .CLKOS2_FPHASE (0),
    .CLKOS3_FPHASE (0),
    .CLKOP_ENABLE  ("ENABLED"),
    .CLKOS_ENABLE  (NUM_OUT > 1 ? "ENABLED" : "DISABLED"),
    .CLKOS2_ENABLE (NUM_OUT > 2 ? "ENABLED" : "DISABLED"),
    .CLKOS3_ENABLE (NUM_OUT > 3 ? "ENABLED" : "DISABLED"),
    .FEEDBK_PATH   ("CLKOP"),
    .PLLRST_ENA    ("ENABLED"),
    .INTFB_WAKE    ("DISABLED"),
    .STDBY_ENABLE  ("DISABLED"),
    .DPHASE_SOURCE ("ENABLED")
  ) u_pll (
    .CLKI         (clkin),
    .CLKFB        (clkout[0]),
    .PHASESEL1    (phasesel[1]),
    .PHASESEL0    (phasesel[0]),
    .PHASEDIR     (phasedir),
    .PHASESTEP    (phasestep),
    .PHASELOADREG (1'b1),
    .STDBY        (1'b0),
    .PLLWAKESYNC  (1'b0),
    .RST          (pll_rst),
    .ENCLKOP      (EN[0]),
    .ENCLKOS      (EN[1]),
    .ENCLKOS2     (EN[2]),
    .ENCLKOS3     (EN[3]),
    .CLKOP        (clkout[0]),
    .CLKOS        (clkout[1]),
    .CLKOS2       (clkout[2]),
    .CLKOS3       (clkout[3]),
    .LOCK         (lock_raw),
    .INTLOCK      (),
    .REFCLK       (),
    .CLKINTFB     ()
  );
`else
  // Behavioural stand-in: locks 50 cycles after RST falls and keeps a
  // per-channel phase tally advanced on each PHASESTEP rising edge.
  localparam int SIM_LOCK_DLY = 50;
  logic [5:0] sim_cnt;
  logic       sim_step_q;
  logic [7:0] sim_phase [4];

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sim_cnt    <= '0;
      sim_step_q <= 1'b1;
      for (int i = 0; i < 4; i++)
        sim_phase[i] <= '0;
    end else begin
      if (pll_rst)
        sim_cnt <= '0;
      else if (sim_cnt != 6'(SIM_LOCK_DLY))
        sim_cnt <= sim_cnt + 1'b1;
      sim_step_q <= phasestep;
      if (phasestep && !sim_step_q)
        sim_phase[phasesel] <= sim_phase[phasesel] +
                               (phasedir ? 8'd1 : 8'hff);
    end
  end

  assign lock_raw = (sim_cnt == 6'(SIM_LOCK_DLY));
  assign clkout   = {4{clkin}} & EN;
`endif

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: scoreboard bench for pll_ctrl. Expected output events
// are queued by the stimulus and matched by a negedge monitor.
module tb_pll_ctrl;
  localparam int NK     = 7;
  localparam int K_RSTF = 0;
  localparam int K_LOCK = 1;
  localparam int K_BUSY = 2;
  localparam int K_SFAL = 3;
  localparam int K_SRIS = 4;
  localparam int K_DONE = 5;
  localparam int K_RELK = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] clkout, rst_out_n;
  logic       locked;
  logic       ps_req = 1'b0;
  logic [1:0] ps_sel = 2'd0;
  logic       ps_dir = 1'b0;
  logic       ps_busy, ps_done;
  logic [7:0] relock_count;
  logic [2:0] state;

  int cyc;
  int n_chk = 0;
  int n_pass = 0;
  int qc[NK][$];
  int qv[NK][$];
  string kname[NK] = '{"rst_fall", "lock_rise", "busy_rise",
                       "step_fall", "step_rise", "ps_done",
                       "relock"};

  pll_ctrl #(
    .NUM_OUT      (2),
    .RST_CYCLES   (16),
    .LOCK_FILTER  (8),
    .LOCK_TIMEOUT (100),
    .PS_SETUP     (4),
    .PS_PULSE     (4)
  ) dut (
    .clkin        (clk),
    .reset_n      (reset_n),
    .clkout       (clkout),
    .rst_out_n    (rst_out_n),
    .locked       (locked),
    .ps_req       (ps_req),
    .ps_sel       (ps_sel),
    .ps_dir       (ps_dir),
    .ps_busy      (ps_busy),
    .ps_done      (ps_done),
    .relock_count (relock_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  task automatic exp_ev(int k, int c, int v);
    qc[k].push_back(c);
    qv[k].push_back(v);
  endtask

  task automatic ev(int k, int v);
    int c, ve, ac;
    if (qc[k].size() == 0) begin
      chk({kname[k], " unexpected"}, cyc, -1);
    end else begin
      c  = qc[k].pop_front();
      ve = qv[k].pop_front();
      ac = cyc;
      if (k == K_LOCK && ac >= c - 1 && ac <= c + 1) ac = c;
      chk({kname[k], " cycle"}, ac, c);
      chk({kname[k], " value"}, v, ve);
    end
  endtask

  logic       p_rst = 1'b1, p_lock = 1'b0;
  logic       p_busy = 1'b0, p_step = 1'b1;
  logic [7:0] p_rel = 8'd0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_rst = 1'b1; p_lock = 1'b0; p_busy = 1'b0;
      p_step = 1'b1; p_rel = 8'd0;
    end else begin
      if (p_rst && !dut.pll_rst) ev(K_RSTF, 0);
      if (!p_lock && locked) ev(K_LOCK, int'(rst_out_n));
      if (!p_busy && ps_busy)
        ev(K_BUSY, int'({dut.phasesel, dut.phasedir}));
      if (p_step && !dut.phasestep)
        ev(K_SFAL, int'({dut.phasesel, dut.phasedir}));
      if (!p_step && dut.phasestep) ev(K_SRIS, 0);
      if (ps_done) ev(K_DONE, int'(dut.sim_phase[dut.phasesel]));
      if (relock_count != p_rel) ev(K_RELK, int'(relock_count));
      p_rst  = dut.pll_rst;
      p_lock = locked;
      p_busy = ps_busy;
      p_step = dut.phasestep;
      p_rel  = relock_count;
    end
  end

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " state"}, int'(state), 0);
    chk({tag, " rst_out_n"}, int'(rst_out_n), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " ps_busy"}, int'(ps_busy), 0);
    chk({tag, " ps_done"}, int'(ps_done), 0);
    chk({tag, " relock"}, int'(relock_count), 0);
    chk({tag, " phasestep"}, int'(dut.phasestep), 1);
    chk({tag, " pll_rst"}, int'(dut.pll_rst), 1);
  endtask

  localparam int END_CYC = 93 + 116 * 254 + 200;

  initial begin
    #1 reset_n = 1'b0;
    #20;
    chk_reset_vals("reset");
    chk("reset phasesel", int'(dut.phasesel), 0);
    chk("reset phasedir", int'(dut.phasedir), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Initial lock: RST 16 cycles, lock 50 later, 2 sync, 8 filter.
    exp_ev(K_RSTF, 16, 0);
    exp_ev(K_LOCK, 77, 1);
    at(90);
    chk("released rst_out_n", int'(rst_out_n), 3);
    chk("run state", int'(state), 3);

    // Two back-to-back lag steps on channel 1.
    at(100);
    exp_ev(K_BUSY, 101, 3);
    exp_ev(K_SFAL, 105, 3);
    exp_ev(K_SRIS, 109, 0);
    exp_ev(K_DONE, 113, 1);
    exp_ev(K_BUSY, 114, 3);
    exp_ev(K_SFAL, 118, 3);
    exp_ev(K_SRIS, 122, 0);
    exp_ev(K_DONE, 126, 2);
    ps_sel = 2'd1; ps_dir = 1'b1; ps_req = 1'b1;
    at(103);
    chk("setup phasesel", int'(dut.phasesel), 1);
    chk("setup phasestep", int'(dut.phasestep), 1);
    at(107);
    chk("pulse phasestep", int'(dut.phasestep), 0);
    at(114);
    ps_req = 1'b0;

    // Request for a disabled channel is ignored.
    at(140);
    ps_sel = 2'd2; ps_req = 1'b1;
    at(145);
    chk("ignored busy", int'(ps_busy), 0);
    chk("ignored state", int'(state), 3);
    at(150);
    ps_req = 1'b0;

    // Abort: lock lost during the PHASESTEP pulse.
    at(160);
    exp_ev(K_BUSY, 161, 0);
    exp_ev(K_SFAL, 165, 0);
    exp_ev(K_SRIS, 168, 0);
    exp_ev(K_RELK, 169, 1);
    exp_ev(K_RSTF, 185, 0);
    exp_ev(K_LOCK, 253, 1);
    ps_sel = 2'd0; ps_dir = 1'b0; ps_req = 1'b1;
    at(161);
    ps_req = 1'b0;
    at(166);
    force dut.lock_raw = 1'b0;
    at(167);
    chk("pre-abort rst_out_n", int'(rst_out_n), 3);
    at(168);
    chk("abort rst_out_n", int'(rst_out_n), 0);
    chk("abort state", int'(state), 5);
    chk("abort phasestep", int'(dut.phasestep), 1);
    chk("abort locked", int'(locked), 0);
    chk("abort busy", int'(ps_busy), 0);
    at(170);
    release dut.lock_raw;

    // One-cycle lock glitch at filter count 5 in STABLE.
    at(241);
    force dut.lock_raw = 1'b0;
    at(242);
    release dut.lock_raw;
    at(243);
    chk("glitch stable", int'(state), 2);
    at(244);
    chk("glitch wait", int'(state), 1);
    at(246);
    chk("glitch locked", int'(locked), 0);
    at(254);
    chk("relock rst_out_n", int'(rst_out_n), 3);
    chk("glitch relock cnt", int'(relock_count), 1);

    // Asynchronous reset in RUN, mid-cycle.
    at(260);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Relock, then lock lost for good: retries every 116 cycles.
    exp_ev(K_RSTF, 16, 0);
    exp_ev(K_LOCK, 77, 1);
    for (int k = 1; k <= 255; k++)
      exp_ev(K_RELK, 93 + 116 * (k - 1), k);
    for (int j = 0; j <= 255; j++)
      exp_ev(K_RSTF, 109 + 116 * j, 0);
    at(90);
    force dut.lock_raw = 1'b0;
    at(END_CYC);
    chk("saturated relock", int'(relock_count), 255);
    chk("timeout locked", int'(locked), 0);
    release dut.lock_raw;

    for (int k = 0; k < NK; k++)
      chk({kname[k], " missing"}, qc[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
